// File: rtl/fap80_bus_pkg.sv
// Shared types and constants for the FAP80 Z80-style memory bus.
package fap80_bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    // Z80 control strobes are active-low; this is their released level.
    localparam logic STROBE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3
    } bus_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/z80_tstate_timer.sv
// Divides clk into Z80 T-states and flags the start, midpoint and last clk of each.
module z80_tstate_timer #(
    parameter int unsigned T_DIV = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic t_start,
    output logic t_half,
    output logic t_end
);

    localparam int unsigned PH_W = (T_DIV > 1) ? $clog2(T_DIV) : 1;
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(T_DIV / 2);
    localparam logic [PH_W-1:0] PH_END  = PH_W'(T_DIV - 1);

    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_next;

    // Restart pins the counter at phase 0 so the first T-state begins cleanly.
    always_comb begin
        phase_next = phase + PH_W'(1);
        if (restart || (phase == PH_END)) begin
            phase_next = '0;
        end
    end

    // Strobes are decoded from the next phase so they line up with the phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= '0;
            t_start <= 1'b1;
            t_half  <= 1'b0;
            t_end   <= 1'b0;
        end else begin
            phase   <= phase_next;
            t_start <= (phase_next == '0);
            t_half  <= (phase_next == PH_HALF);
            t_end   <= (phase_next == PH_END);
        end
    end

endmodule

// File: rtl/z80_bus_master.sv
// Single-beat request/response initiator that runs Z80-timed memory read/write
// cycles (T1, T2, optional TW, T3) on the FAP80 backplane.
module z80_bus_master
    import fap80_bus_pkg::*;
#(
    parameter int unsigned T_DIV        = 12,
    parameter int unsigned MIN_WAIT     = 0,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data_out,
    output logic              cpu_data_oe,
    input  logic [DATA_W-1:0] cpu_data_in,
    output logic              cpu_mreq,
    output logic              cpu_rd,
    output logic              cpu_wr,
    input  logic              cpu_wait_n
);

    localparam int unsigned WCNT_W = 8;
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

    bus_state_e        state;
    bus_state_e        state_next;
    bus_req_t          req_in;
    logic              accept;
    logic              t_start;
    logic              t_half;
    logic              t_end;
    logic              wait_meta;
    logic              wait_s;
    logic              write_q;
    logic              need_wait;
    logic              wait_ready;
    logic              abort;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_inc;
    logic              leave_tw;
    logic              hit_timeout;

    logic              req_ready_d;
    logic              rsp_valid_d;
    logic              rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic [ADDR_W-1:0] cpu_addr_d;
    logic [DATA_W-1:0] cpu_data_out_d;
    logic              cpu_data_oe_d;
    logic              cpu_mreq_d;
    logic              cpu_rd_d;
    logic              cpu_wr_d;

    assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign accept = req_valid && req_ready;

    z80_tstate_timer #(
        .T_DIV (T_DIV)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (state == IDLE),
        .t_start (t_start),
        .t_half  (t_half),
        .t_end   (t_end)
    );

    // WAIT is asynchronous to clk; two flops before anything looks at it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_meta <= 1'b1;
            wait_s    <= 1'b1;
        end else begin
            wait_meta <= cpu_wait_n;
            wait_s    <= wait_meta;
        end
    end

    assign wait_cnt_inc = (wait_cnt == WCNT_MAX) ? wait_cnt : wait_cnt + WCNT_W'(1);
    assign leave_tw     = wait_ready && (32'(wait_cnt_inc) >= MIN_WAIT);
    assign hit_timeout  = 32'(wait_cnt_inc) >= WAIT_TIMEOUT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = T1;
            T1:   if (t_end)  state_next = T2;
            T2:   if (t_end)  state_next = need_wait ? TW : T3;
            TW:   if (t_end && (leave_tw || hit_timeout)) state_next = T3;
            T3:   if (t_end)  state_next = IDLE;
            default:          state_next = IDLE;
        endcase
    end

    // Next values for every registered output; strobes hold unless a phase moves them.
    always_comb begin
        req_ready_d    = (state_next == IDLE);
        rsp_valid_d    = 1'b0;
        rsp_err_d      = 1'b0;
        rsp_rdata_d    = rsp_rdata;
        cpu_addr_d     = cpu_addr;
        cpu_data_out_d = cpu_data_out;
        cpu_data_oe_d  = cpu_data_oe;
        cpu_mreq_d     = cpu_mreq;
        cpu_rd_d       = cpu_rd;
        cpu_wr_d       = cpu_wr;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cpu_addr_d = req_in.addr;
                    if (req_in.write) begin
                        cpu_data_out_d = req_in.wdata;
                    end
                end
            end
            T1: begin
                if (t_half) begin
                    cpu_mreq_d = ~STROBE_IDLE;
                    if (write_q) begin
                        cpu_data_oe_d = 1'b1;
                    end else begin
                        cpu_rd_d = ~STROBE_IDLE;
                    end
                end
            end
            T2: begin
                if (t_half && write_q) begin
                    cpu_wr_d = ~STROBE_IDLE;
                end
            end
            T3: begin
                if (t_half) begin
                    cpu_mreq_d = STROBE_IDLE;
                    cpu_rd_d   = STROBE_IDLE;
                    cpu_wr_d   = STROBE_IDLE;
                    if (!write_q && !abort) begin
                        rsp_rdata_d = cpu_data_in;
                    end
                end
                if (t_end) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = abort;
                    cpu_data_oe_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            cpu_addr     <= '0;
            cpu_data_out <= '0;
            cpu_data_oe  <= 1'b0;
            cpu_mreq     <= STROBE_IDLE;
            cpu_rd       <= STROBE_IDLE;
            cpu_wr       <= STROBE_IDLE;
        end else begin
            req_ready    <= req_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_err      <= rsp_err_d;
            rsp_rdata    <= rsp_rdata_d;
            cpu_addr     <= cpu_addr_d;
            cpu_data_out <= cpu_data_out_d;
            cpu_data_oe  <= cpu_data_oe_d;
            cpu_mreq     <= cpu_mreq_d;
            cpu_rd       <= cpu_rd_d;
            cpu_wr       <= cpu_wr_d;
        end
    end

    // Per-transaction bookkeeping: direction, WAIT sampling, TW count and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q    <= 1'b0;
            need_wait  <= 1'b0;
            wait_ready <= 1'b0;
            wait_cnt   <= '0;
            abort      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        write_q  <= req_in.write;
                        wait_cnt <= '0;
                        abort    <= 1'b0;
                    end
                end
                T2: begin
                    if (t_half) begin
                        need_wait <= !wait_s || (MIN_WAIT > 0);
                    end
                end
                TW: begin
                    if (t_start) begin
                        wait_ready <= 1'b0;
                    end
                    if (t_half) begin
                        wait_ready <= wait_s;
                    end
                    if (t_end) begin
                        wait_cnt <= wait_cnt_inc;
                        if (!leave_tw && hit_timeout) begin
                            abort <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/z80_bus_master.md
Name: z80_bus_master

Overview:
- Initiator for the FAP80 Z80 memory bus: turns a single-beat request/response handshake into Z80-timed memory read/write cycles (MREQ/RD/WR, address, data, WAIT).
- Drives the same bus that the video card's CPU register/VRAM port responds to.
- Used as a DMA/test-traffic source on the backplane and as a synthesizable exerciser for the video card.
- One transaction at a time, no pipelining.

Parameters:
- T_DIV, 12, clk cycles per Z80 T-state; even, >=2 (50MHz/12 ~ 4.17MHz bus)
- MIN_WAIT, 0, forced TW states inserted in every cycle regardless of WAIT
- WAIT_TIMEOUT, 255, max TW states before abort; width 8 bits

Ports:
- clk  in  1  system clock (50MHz)
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, will accept request this cycle
- req_write  in  1  1=memory write, 0=memory read
- req_addr  in  16  bus address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-clk completion pulse
- rsp_rdata  out  8  read data, valid with rsp_valid on reads (holds last value otherwise)
- rsp_err  out  1  with rsp_valid: WAIT timeout abort
- cpu_addr  out  16  bus address
- cpu_data_out  out  8  bus write data
- cpu_data_oe  out  1  1=drive cpu_data (top-level tristate)
- cpu_data_in  in  8  bus read data
- cpu_mreq  out  1  active-low
- cpu_rd  out  1  active-low
- cpu_wr  out  1  active-low
- cpu_wait_n  in  1  active-low WAIT, asynchronous

Behaviour:
- Reset values:
  - cpu_mreq, cpu_rd, cpu_wr = 1
  - cpu_data_oe, rsp_valid, rsp_err = 0
  - cpu_addr, cpu_data_out, rsp_rdata = 0
  - req_ready = 0 during rst, 1 the cycle after
  - state = IDLE
- cpu_wait_n passes through a 2-flop synchronizer; all sampling uses the synchronized value (wait_s).
- Phase counter 0..T_DIV-1 per T-state:
  - "start" = phase 0
  - "half" = phase T_DIV/2
  - "end" = phase T_DIV-1
- States: IDLE, T1, T2, TW, T3.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch write/addr/wdata, drive cpu_addr (and cpu_data_out for writes), go to T1 phase 0 next clk.
  - Requests are ignored (not consumed) outside IDLE.
- T1:
  - At half: cpu_mreq=0, and cpu_rd=0 (read) or cpu_data_oe=1 (write).
  - At end: go to T2.
- T2:
  - Write: cpu_wr=0 at half.
  - At half: sample wait_s; record need_wait = (wait_s==0) || (MIN_WAIT>0).
  - At end: go to TW if need_wait, else T3.
- TW:
  - Increments a wait counter at each end.
  - Resampled at half: leave to T3 at end when wait_s==1 and forced count >= MIN_WAIT.
  - If the counter reaches WAIT_TIMEOUT, go to T3 with abort flag set.
- T3:
  - Read: capture cpu_data_in into rsp_rdata at half, the same clk cpu_mreq/cpu_rd return to 1.
  - Write: cpu_mreq/cpu_wr return to 1 at half; cpu_data_oe stays 1 through end.
  - At end: rsp_valid=1 for that single clk, rsp_err=abort; cpu_data_oe=0; next clk IDLE.
- Abort: bus cycle is still terminated cleanly in T3. rsp_rdata is not updated on an aborted read.
- cpu_addr is held stable from T1 start through T3 end; it keeps its last value in IDLE.
- Latency, no waits: accept edge -> rsp_valid after 3*T_DIV clks. Back-to-back throughput is one transaction per 3*T_DIV+1 clks.
- Each TW state adds exactly T_DIV clks.
- rst mid-cycle: on the same edge, all strobes go to 1, oe=0, state=IDLE. No rsp_valid is emitted and the transaction is lost.
- Simultaneous rsp_valid and new req_valid: the request is not accepted until the next clk (req_ready=0 in T3).
- Phase counter width: $clog2(T_DIV). Wait counter: 8 bits, saturating.

Decomposition:
- Package fap80_bus_pkg:
  - state enum {IDLE,T1,T2,TW,T3}
  - Z80 strobe inactive level constant (1'b1)
  - ADDR_W=16, DATA_W=8
- Sub-module z80_tstate_timer: phase counter with restart input; outputs t_start, t_half, t_end strobes for a given T_DIV.
- Top FSM consumes these strobes.

Test Plan (T_DIV=4, MIN_WAIT=0):
- Read 0x8000, bus returns 0xA5, wait_n=1:
  - mreq/rd low from clk 3 to clk 11 after accept.
  - rsp_valid at clk 12 with rdata=0xA5, err=0.
- Write 0x9001 data 0x3C:
  - oe high clks 3-12.
  - wr low clks 7-11.
  - addr stable 0x9001 throughout.
  - rsp_valid once.
- Read with wait_n low for 10 clks during T2: integer number of TW states inserted; rsp_valid delayed by 4*nTW; data still captured correctly.
- wait_n held low, WAIT_TIMEOUT=3:
  - exactly 3 TW then T3.
  - rsp_err=1, strobes released.
  - rsp_rdata unchanged.
- rst asserted during write T2: next clk mreq=wr=1, oe=0, req_ready=1 after rst, no rsp_valid.
- Two requests with req_valid held high: second accepted exactly 13 clks after first; no overlap of mreq low periods.
